jar_pi_reader: RTL and testbench

//  Host-side reader for the pi digit generator. Accepts a 10-bit start index and a digit count

---
 rtl/jar_pi_reader.sv | 180 ++++++++++++++++++
 tb/tb_jar_pi_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jar_pi_reader.sv
// rtl/jar_pi_reader.sv - host-side reader for the pi digit generator
// Loads a 10-bit start index into the generator over two pi_reset cycles,
// then steps it with pi_stream pulses. After each step it samples the
// 7-segment pattern and emits one decoded digit.
// Optional feature macro: SEG_DECODE_EN. When it is defined, the 7-segment
// decode table is built in. When it is undefined, digit_out is 0 and
// seg_err stays 0.
module jar_pi_reader #(
  parameter int COUNT_W     = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [9:0]         start_idx,
  input  logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               pi_reset,
  output logic               pi_stream,
  output logic [4:0]         pi_index,
  input  logic [7:0]         seg_in,
  output logic               digit_valid,
  output logic [3:0]         digit_out,
  output logic [9:0]         digit_idx,
  output logic [7:0]         seg_raw,
  output logic               seg_err
);

  // A wait of zero would sample before the generator's registered output
  // has caught up, so clamp the wait to at least one cycle.
  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int WCNT_W   = $clog2(WAIT_EFF + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_LO,
    S_LOAD_HI,
    S_WAIT,
    S_SAMPLE,
    S_STEP,
    S_DONE
  } state_t;

  state_t             state;
  logic [9:0]         cur_idx;    // local mirror of the generator's index
  logic [4:0]         hi_idx;     // upper index half, driven in LOAD_HI
  logic [COUNT_W-1:0] remaining;
  logic [WCNT_W-1:0]  wait_cnt;

`ifdef SEG_DECODE_EN
  // Returns {unrecognised, digit}. The dp bit is ignored by the caller.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   seg_decode = {1'b0, 4'd0};
      7'h06:   seg_decode = {1'b0, 4'd1};
      7'h5B:   seg_decode = {1'b0, 4'd2};
      7'h4F:   seg_decode = {1'b0, 4'd3};
      7'h66:   seg_decode = {1'b0, 4'd4};
      7'h6D:   seg_decode = {1'b0, 4'd5};
      7'h7D:   seg_decode = {1'b0, 4'd6};
      7'h07:   seg_decode = {1'b0, 4'd7};
      7'h7F:   seg_decode = {1'b0, 4'd8};
      7'h6F:   seg_decode = {1'b0, 4'd9};
      default: seg_decode = {1'b1, 4'hF};
    endcase
  endfunction
`endif

  // Reader FSM. Each output is set on the edge that enters the state it
  // belongs to, so the outputs are registered and line up with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cur_idx     <= '0;
      hi_idx      <= '0;
      remaining   <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pi_reset    <= 1'b0;
      pi_stream   <= 1'b0;
      pi_index    <= '0;
      digit_valid <= 1'b0;
      digit_out   <= '0;
      digit_idx   <= '0;
      seg_raw     <= '0;
      seg_err     <= 1'b0;
    end else begin
      // Pulse outputs default low each cycle.
      done        <= 1'b0;
      digit_valid <= 1'b0;
      pi_reset    <= 1'b0;
      pi_stream   <= 1'b0;
      pi_index    <= '0;

      case (state)
        S_IDLE: begin
          if (start && !busy) begin
            cur_idx   <= start_idx;
            hi_idx    <= start_idx[9:5];
            remaining <= count;
            seg_err   <= 1'b0;
            if (count == '0) begin
              // An empty run: report completion without touching the generator.
              done <= 1'b1;
            end else begin
              state    <= S_LOAD_LO;
              busy     <= 1'b1;
              pi_reset <= 1'b1;
              pi_index <= start_idx[4:0];
            end
          end
        end

        S_LOAD_LO: begin
          state    <= S_LOAD_HI;
          pi_reset <= 1'b1;
          pi_index <= hi_idx;
        end

        S_LOAD_HI: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end

        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_SAMPLE: begin
          seg_raw     <= seg_in;
          digit_idx   <= cur_idx;
          digit_valid <= 1'b1;
`ifdef SEG_DECODE_EN
          digit_out   <= seg_decode(seg_in[6:0])[3:0];
          if (seg_decode(seg_in[6:0])[4]) begin
            seg_err <= 1'b1;
          end
`else
          digit_out   <= 4'd0;
`endif
          remaining   <= remaining - 1'b1;
          if (remaining == COUNT_W'(1)) begin
            // Last digit: busy drops together with the done pulse.
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state     <= S_STEP;
            pi_stream <= 1'b1;
          end
        end

        S_STEP: begin
          // The generator increments on this edge. Its 10-bit index wraps
          // from 1023 to 0, and so does this one.
          cur_idx  <= cur_idx + 10'd1;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jar_pi_reader.sv
// tb/tb_jar_pi_reader.sv - self-checking bench for jar_pi_reader with a behavioural generator model
module tb_jar_pi_reader;

  localparam int W = 2;
`ifdef SEG_DECODE_EN
  localparam bit SEG = 1'b1;
`else
  localparam bit SEG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] start_idx = '0;
  logic [9:0] count = '0;
  logic       busy, done, pi_reset, pi_stream, digit_valid, seg_err;
  logic [4:0] pi_index;
  logic [7:0] seg_in, seg_raw;
  logic [3:0] digit_out;
  logic [9:0] digit_idx;

  jar_pi_reader #(.COUNT_W(10), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_idx(start_idx), .count(count),
    .busy(busy), .done(done), .pi_reset(pi_reset), .pi_stream(pi_stream), .pi_index(pi_index),
    .seg_in(seg_in), .digit_valid(digit_valid), .digit_out(digit_out), .digit_idx(digit_idx),
    .seg_raw(seg_raw), .seg_err(seg_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Digits at indices 0..7 are 3,1,4,1,5,9,2,6. Other indices use i mod 10.
  function automatic logic [3:0] digit_of(input logic [9:0] i);
    case (i)
      10'd0: digit_of = 4'd3;
      10'd1: digit_of = 4'd1;
      10'd2: digit_of = 4'd4;
      10'd3: digit_of = 4'd1;
      10'd4: digit_of = 4'd5;
      10'd5: digit_of = 4'd9;
      10'd6: digit_of = 4'd2;
      10'd7: digit_of = 4'd6;
      default: digit_of = 4'(i % 10'd10);
    endcase
  endfunction

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: seg_pat = 7'h3F;  4'd1: seg_pat = 7'h06;  4'd2: seg_pat = 7'h5B;
      4'd3: seg_pat = 7'h4F;  4'd4: seg_pat = 7'h66;  4'd5: seg_pat = 7'h6D;
      4'd6: seg_pat = 7'h7D;  4'd7: seg_pat = 7'h07;  4'd8: seg_pat = 7'h7F;
      default: seg_pat = 7'h6F;
    endcase
  endfunction

  // Generator model: two-cycle load (low half first), increment on stream, registered output.
  logic [9:0] gen_idx = '0;
  logic [4:0] gen_lo = '0;
  logic       gen_prev_rst = 1'b0;
  logic [7:0] gen_seg = '0;
  logic       dp_on = 1'b0;
  logic       corrupt_en = 1'b0;
  logic [9:0] corrupt_idx = '0;

  always @(posedge clk) begin
    if (pi_reset) begin
      if (!gen_prev_rst) gen_lo <= pi_index;
      else gen_idx <= {pi_index, gen_lo};
    end else if (pi_stream) begin
      gen_idx <= gen_idx + 10'd1;
    end
    gen_prev_rst <= pi_reset;
    gen_seg <= (corrupt_en && gen_idx == corrupt_idx) ? 8'h00 : {dp_on, seg_pat(digit_of(gen_idx))};
  end
  assign seg_in = gen_seg;

  // Monitor: record everything the DUT emits during a run.
  logic [3:0] obs_dig[$];
  logic [9:0] obs_idx[$];
  logic [7:0] obs_raw[$];
  logic       obs_err[$];
  logic [4:0] obs_load[$];
  int n_done, n_stream, n_viol, first_valid_cyc, done_cyc;

  always @(negedge clk) begin
    if (reset_n) begin
      if (digit_valid) begin
        obs_dig.push_back(digit_out);
        obs_idx.push_back(digit_idx);
        obs_raw.push_back(seg_raw);
        obs_err.push_back(seg_err);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (busy) n_viol++;
      end
      if (pi_stream) n_stream++;
      if (pi_reset) obs_load.push_back(pi_index);
      if (pi_reset && pi_stream) n_viol++;
      if (!pi_reset && pi_index != 5'd0) n_viol++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    obs_dig.delete(); obs_idx.delete(); obs_raw.delete(); obs_err.delete(); obs_load.delete();
    n_done = 0; n_stream = 0; n_viol = 0; first_valid_cyc = -1; done_cyc = -1;
  endtask

  task automatic do_run(input logic [9:0] sidx, input logic [9:0] cnt, input bit hammer, output int acc);
    int t;
    clr_mon();
    @(negedge clk);
    start = 1'b1; start_idx = sidx; count = cnt; acc = cyc;
    t = 0;
    while (t < 3000) begin
      @(negedge clk);
      t++;
      if (!hammer) begin
        start = 1'b0; start_idx = 10'($urandom); count = 10'($urandom);
      end
      if (done) break;
    end
    start = 1'b0;
    if (t >= 3000) begin
      tests++; fails++;
      $display("FAIL timeout: got no done expected done within 3000 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic verify(input string nm, input logic [9:0] sidx, input logic [9:0] cnt, input int acc,
                        input logic [31:0] tab, input bit use_tab);
    bit err_seen;
    bit hit;
    logic [9:0] ix;
    logic [3:0] ed;
    logic [7:0] er;
    err_seen = 1'b0;
    chk({nm, " done_count"}, n_done, 1);
    chk({nm, " digit_count"}, obs_dig.size(), 32'(cnt));
    chk({nm, " stream_pulses"}, n_stream, (cnt == 0) ? 0 : 32'(cnt) - 1);
    chk({nm, " load_cycles"}, obs_load.size(), (cnt == 0) ? 0 : 2);
    chk({nm, " invariants"}, n_viol, 0);
    chk({nm, " busy_after"}, busy, 0);
    if (cnt == 0) begin
      chk({nm, " done_cycle"}, done_cyc, acc + 1);
    end else begin
      chk({nm, " first_valid_cycle"}, first_valid_cyc, acc + 4 + W);
      chk({nm, " done_cycle"}, done_cyc, acc + 4 + W + (32'(cnt) - 1) * (W + 2));
      if (obs_load.size() == 2) begin
        chk({nm, " load_lo"}, obs_load[0], sidx[4:0]);
        chk({nm, " load_hi"}, obs_load[1], sidx[9:5]);
      end
      chk({nm, " gen_idx_end"}, gen_idx, 10'(sidx + cnt - 10'd1));
    end
    for (int k = 0; k < obs_dig.size() && k < 32'(cnt); k++) begin
      ix = sidx + 10'(k);
      hit = corrupt_en && (ix == corrupt_idx);
      ed = hit ? 4'hF : ((use_tab && k < 8) ? tab[4*k +: 4] : digit_of(ix));
      if (!SEG) ed = 4'd0;
      er = hit ? 8'h00 : {dp_on, seg_pat(digit_of(ix))};
      if (hit && SEG) err_seen = 1'b1;
      chk($sformatf("%s digit[%0d]", nm, k), obs_dig[k], ed);
      chk($sformatf("%s idx[%0d]", nm, k), obs_idx[k], ix);
      chk($sformatf("%s raw[%0d]", nm, k), obs_raw[k], er);
      chk($sformatf("%s err[%0d]", nm, k), obs_err[k], err_seen);
    end
    chk({nm, " seg_err_end"}, seg_err, err_seen);
  endtask

  typedef struct {
    logic [9:0]  sidx;
    logic [9:0]  cnt;
    logic [31:0] digits;  // expected digit k in nibble k
  } vec_t;

  vec_t vecs[5];
  int acc;

  initial begin
    vecs[0] = '{sidx: 10'd0,    cnt: 10'd5, digits: 32'h0005_1413};
    vecs[1] = '{sidx: 10'h3FF,  cnt: 10'd3, digits: 32'h0000_0133};
    vecs[2] = '{sidx: 10'd0,    cnt: 10'd0, digits: 32'h0000_0000};
    vecs[3] = '{sidx: 10'd5,    cnt: 10'd2, digits: 32'h0000_0029};
    vecs[4] = '{sidx: 10'd2,    cnt: 10'd6, digits: 32'h0062_9514};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, pi_reset, pi_stream, pi_index, digit_valid,
                          digit_out, digit_idx, seg_raw, seg_err}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      do_run(vecs[i].sidx, vecs[i].cnt, 1'b0, acc);
      verify($sformatf("vec%0d", i), vecs[i].sidx, vecs[i].cnt, acc, vecs[i].digits, 1'b1);
    end

    // Start held high through a 4-digit run, then a normal run
    do_run(10'd1, 10'd4, 1'b1, acc);
    verify("hammer", 10'd1, 10'd4, acc, 32'h0000_5141, 1'b1);
    do_run(10'd3, 10'd2, 1'b0, acc);
    verify("after_hammer", 10'd3, 10'd2, acc, 32'h0000_0051, 1'b1);

    // Async reset during the WAIT of digit 2
    clr_mon();
    @(negedge clk);
    start = 1'b1; start_idx = 10'd0; count = 10'd4; acc = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + W + 5) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, pi_reset, pi_stream, pi_index, digit_valid,
                                digit_out, digit_idx, seg_raw, seg_err}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_reset", n_done, 0);
    chk("digits_before_reset", obs_dig.size(), 1);
    chk("idle_after_reset", busy, 0);
    do_run(10'd5, 10'd2, 1'b0, acc);
    verify("post_reset", 10'd5, 10'd2, acc, 32'h0000_0029, 1'b1);

    // Corrupt pattern at index 2, sticky error until the next accepted start
    corrupt_en = 1'b1; corrupt_idx = 10'd2;
    do_run(10'd0, 10'd5, 1'b0, acc);
    verify("corrupt", 10'd0, 10'd5, acc, 32'h0005_1413, 1'b1);
    corrupt_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("seg_err_sticky", seg_err, SEG);
    do_run(10'd5, 10'd2, 1'b0, acc);
    verify("err_cleared", 10'd5, 10'd2, acc, 32'h0000_0029, 1'b1);

    // Randomised runs against the model
    for (int r = 0; r < 20; r++) begin
      logic [9:0] s;
      logic [9:0] c;
      s = 10'($urandom_range(0, 1023));
      c = 10'($urandom_range(0, 6));
      dp_on = 1'($urandom);
      corrupt_en = ($urandom_range(0, 3) == 0);
      corrupt_idx = s + 10'($urandom_range(0, 5));
      do_run(s, c, 1'b0, acc);
      verify($sformatf("rand%0d", r), s, c, acc, 32'h0, 1'b0);
    end
    corrupt_en = 1'b0;
    dp_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
